// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared 7-segment patterns, bit indices and monitor state encoding
package seven_segment_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Lit-high patterns, bit order ABCDEFG
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_HA    = 7'b1110111;
    localparam logic [6:0] SEG_HB    = 7'b0011111;
    localparam logic [6:0] SEG_HC    = 7'b1001110;
    localparam logic [6:0] SEG_HD    = 7'b0111101;
    localparam logic [6:0] SEG_HE    = 7'b1001111;
    localparam logic [6:0] SEG_HF    = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        S_SETTLE = 1'b0,
        S_LOCKED = 1'b1
    } seg_state_t;

    // Encoder-side view of the same table, so both ends of a loopback agree
    function automatic logic [6:0] seg_encode(input logic [3:0] i_value);
        logic [6:0] w_pat;
        case (i_value)
            4'h0:    w_pat = SEG_0;
            4'h1:    w_pat = SEG_1;
            4'h2:    w_pat = SEG_2;
            4'h3:    w_pat = SEG_3;
            4'h4:    w_pat = SEG_4;
            4'h5:    w_pat = SEG_5;
            4'h6:    w_pat = SEG_6;
            4'h7:    w_pat = SEG_7;
            4'h8:    w_pat = SEG_8;
            4'h9:    w_pat = SEG_9;
            4'hA:    w_pat = SEG_HA;
            4'hB:    w_pat = SEG_HB;
            4'hC:    w_pat = SEG_HC;
            4'hD:    w_pat = SEG_HD;
            4'hE:    w_pat = SEG_HE;
            default: w_pat = SEG_HF;
        endcase
        return w_pat;
    endfunction

endpackage

// File: rtl/seven_segment_pattern_lut.sv
// rtl/seven_segment_pattern_lut.sv - combinational lit-high pattern to hex value / blank / legal classifier
module seven_segment_pattern_lut
    import seven_segment_pkg::*;
(
    input  logic [6:0] i_Pattern,
    output logic       o_Legal,
    output logic       o_Blank,
    output logic [3:0] o_Value
);

    always_comb begin
        o_Legal = 1'b1;
        o_Blank = 1'b0;
        o_Value = 4'h0;
        case (i_Pattern)
            SEG_0:     o_Value = 4'h0;
            SEG_1:     o_Value = 4'h1;
            SEG_2:     o_Value = 4'h2;
            SEG_3:     o_Value = 4'h3;
            SEG_4:     o_Value = 4'h4;
            SEG_5:     o_Value = 4'h5;
            SEG_6:     o_Value = 4'h6;
            SEG_7:     o_Value = 4'h7;
            SEG_8:     o_Value = 4'h8;
            SEG_9:     o_Value = 4'h9;
            SEG_HA:    o_Value = 4'hA;
            SEG_HB:    o_Value = 4'hB;
            SEG_HC:    o_Value = 4'hC;
            SEG_HD:    o_Value = 4'hD;
            SEG_HE:    o_Value = 4'hE;
            SEG_HF:    o_Value = 4'hF;
            SEG_BLANK: begin
                o_Legal = 1'b0;
                o_Blank = 1'b1;
            end
            default:   o_Legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_decoder_monitor.sv
// rtl/seven_segment_decoder_monitor.sv - debounced 7-segment bus decoder with legal/blank/illegal flags
module seven_segment_decoder_monitor
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 250000,  // must be >= 2
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_Segments,
    output logic [3:0] o_Binary_Num,
    output logic       o_Valid,
    output logic       o_Blank,
    output logic       o_Error,
    output logic       o_Change,
    output logic [7:0] o_Error_Count
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);

    logic [6:0]    r_Sample;
    logic [6:0]    r_Prev;
    logic [CW-1:0] r_Count;
    seg_state_t    r_State;
    seg_state_t    w_State_Next;
    logic          w_Commit;
    logic          w_Same;
    logic [6:0]    w_Sample_In;

    logic          w_Legal;
    logic          w_Is_Blank;
    logic [3:0]    w_Value;

    logic [3:0]    r_Binary_Num;
    logic          r_Valid;
    logic          r_Blank;
    logic          r_Error;
    logic          r_Change;
    logic [7:0]    r_Error_Count;

    assign w_Sample_In = ACTIVE_LOW ? ~i_Segments : i_Segments;
    assign w_Same      = (r_Sample == r_Prev);

    seven_segment_pattern_lut u_lut (
        .i_Pattern (r_Sample),
        .o_Legal   (w_Legal),
        .o_Blank   (w_Is_Blank),
        .o_Value   (w_Value)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= S_SETTLE;
        end else begin
            r_State <= w_State_Next;
        end
    end

    // Commit fires on the edge where the counter steps into CNT_MAX
    always_comb begin
        w_State_Next = r_State;
        w_Commit     = 1'b0;
        case (r_State)
            S_SETTLE: begin
                if (w_Same && (r_Count == CNT_PRE)) begin
                    w_Commit     = 1'b1;
                    w_State_Next = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (!w_Same) begin
                    w_State_Next = S_SETTLE;
                end
            end
            default: w_State_Next = S_SETTLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Sample      <= 7'd0;
            r_Prev        <= 7'd0;
            r_Count       <= '0;
            r_Binary_Num  <= 4'h0;
            r_Valid       <= 1'b0;
            r_Blank       <= 1'b0;
            r_Error       <= 1'b0;
            r_Change      <= 1'b0;
            r_Error_Count <= 8'd0;
        end else begin
            r_Sample <= w_Sample_In;
            r_Prev   <= r_Sample;
            r_Change <= 1'b0;

            if (!w_Same) begin
                r_Count <= '0;
            end else if (r_Count != CNT_MAX) begin
                r_Count <= r_Count + 1'b1;
            end

            if (w_Commit) begin
                if (w_Legal) begin
                    r_Binary_Num <= w_Value;
                    r_Valid      <= 1'b1;
                    r_Blank      <= 1'b0;
                    r_Error      <= 1'b0;
                    r_Change     <= (w_Value != r_Binary_Num) || !r_Valid;
                end else if (w_Is_Blank) begin
                    r_Valid <= 1'b0;
                    r_Blank <= 1'b1;
                    r_Error <= 1'b0;
                end else begin
                    r_Valid <= 1'b0;
                    r_Blank <= 1'b0;
                    r_Error <= 1'b1;
                    if (r_Error_Count != 8'hFF) begin
                        r_Error_Count <= r_Error_Count + 8'd1;
                    end
                end
            end
        end
    end

    assign o_Binary_Num  = r_Binary_Num;
    assign o_Valid       = r_Valid;
    assign o_Blank       = r_Blank;
    assign o_Error       = r_Error;
    assign o_Change      = r_Change;
    assign o_Error_Count = r_Error_Count;

endmodule

// File: tb/tb_seven_segment_decoder_monitor.sv
// tb/tb_seven_segment_decoder_monitor.sv - directed bench for seven_segment_decoder_monitor
module tb_seven_segment_decoder_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] num;
    logic       valid, blank, err, chg;
    logic [7:0] err_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    int n_chg  = 0;
    int saw_err = 0;

    always #5 clk = ~clk;

    seven_segment_decoder_monitor #(
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Segments    (seg),
        .o_Binary_Num  (num),
        .o_Valid       (valid),
        .o_Blank       (blank),
        .o_Error       (err),
        .o_Change      (chg),
        .o_Error_Count (err_cnt)
    );

    typedef struct {
        logic [6:0] lit;
        logic [3:0] num;
        logic       valid;
        logic       blank;
        logic       err;
        int         changes;
        int         errcnt;
    } vec_t;

    vec_t       tbl[13];
    logic [6:0] enc[16];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            n_chg += int'(chg);
            if (err) saw_err = 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_lit(input logic [6:0] lit);
        seg = ~lit;
    endtask

    initial begin
        enc[0]  = 7'b1111110; enc[1]  = 7'b0110000; enc[2]  = 7'b1101101; enc[3]  = 7'b1111001;
        enc[4]  = 7'b0110011; enc[5]  = 7'b1011011; enc[6]  = 7'b1011111; enc[7]  = 7'b1110000;
        enc[8]  = 7'b1111111; enc[9]  = 7'b1111011; enc[10] = 7'b1110111; enc[11] = 7'b0011111;
        enc[12] = 7'b1001110; enc[13] = 7'b0111101; enc[14] = 7'b1001111; enc[15] = 7'b1000111;

        tbl[0]  = '{7'b1110111, 4'hA, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[1]  = '{7'b1110111, 4'hA, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{7'b0000000, 4'hA, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[3]  = '{7'b1110111, 4'hA, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[4]  = '{7'b1000001, 4'hA, 1'b0, 1'b0, 1'b1, 0, 1};
        tbl[5]  = '{7'b1111110, 4'h0, 1'b1, 1'b0, 1'b0, 1, 1};
        tbl[6]  = '{7'b0000001, 4'h0, 1'b0, 1'b0, 1'b1, 0, 2};
        tbl[7]  = '{7'b1111111, 4'h8, 1'b1, 1'b0, 1'b0, 1, 2};
        tbl[8]  = '{7'b0011111, 4'hB, 1'b1, 1'b0, 1'b0, 1, 2};
        tbl[9]  = '{7'b1000111, 4'hF, 1'b1, 1'b0, 1'b0, 1, 2};
        tbl[10] = '{7'b0110000, 4'h1, 1'b1, 1'b0, 1'b0, 1, 2};
        tbl[11] = '{7'b0000000, 4'h1, 1'b0, 1'b1, 1'b0, 0, 2};
        tbl[12] = '{7'b0110000, 4'h1, 1'b1, 1'b0, 1'b0, 1, 2};

        // Reset with all segments off
        rst = 1'b1;
        seg = 7'b1111111;
        tick(2);
        check("reset_num", int'(num), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_blank", int'(blank), 0);
        check("reset_err", int'(err), 0);
        check("reset_chg", int'(chg), 0);
        check("reset_errcnt", int'(err_cnt), 0);
        rst = 1'b0;

        // Blank commit
        n_chg = 0;
        tick(10);
        check("blank_flag", int'(blank), 1);
        check("blank_valid", int'(valid), 0);
        check("blank_err", int'(err), 0);
        check("blank_no_change", n_chg, 0);

        // Digit 3: exact five-edge latency and single change pulse
        drive_lit(7'b1111001);
        tick(4);
        check("d3_not_yet_valid", int'(valid), 0);
        tick(1);
        check("d3_valid_edge5", int'(valid), 1);
        check("d3_num", int'(num), 3);
        check("d3_change_edge5", int'(chg), 1);
        check("d3_blank_cleared", int'(blank), 0);
        tick(1);
        check("d3_change_one_cycle", int'(chg), 0);
        n_chg = 0;
        tick(20);
        check("d3_hold_no_change", n_chg, 0);

        // Two-cycle glitch then digit 3 again
        n_chg = 0;
        saw_err = 0;
        drive_lit(7'b0000001);
        tick(2);
        drive_lit(7'b1111001);
        tick(6);
        check("glitch_no_error", saw_err, 0);
        check("glitch_no_change", n_chg, 0);
        check("glitch_num", int'(num), 3);
        check("glitch_valid", int'(valid), 1);
        check("glitch_errcnt", int'(err_cnt), 0);

        // Table-driven commits
        for (int i = 0; i < 13; i++) begin
            n_chg = 0;
            drive_lit(tbl[i].lit);
            tick(7);
            check($sformatf("tbl%0d_num", i), int'(num), int'(tbl[i].num));
            check($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].valid));
            check($sformatf("tbl%0d_blank", i), int'(blank), int'(tbl[i].blank));
            check($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].err));
            check($sformatf("tbl%0d_changes", i), n_chg, tbl[i].changes);
            check($sformatf("tbl%0d_errcnt", i), int'(err_cnt), tbl[i].errcnt);
        end

        // 300 illegal commits separated by digits: count saturates at 255
        for (int i = 0; i < 300; i++) begin
            drive_lit(7'b1000001);
            tick(6);
            check($sformatf("sat%0d_err", i), int'(err), 1);
            check($sformatf("sat%0d_num", i), int'(num), (i == 0) ? 1 : ((i % 2 == 1) ? 1 : 7));
            check($sformatf("sat%0d_errcnt", i), int'(err_cnt), (3 + i > 255) ? 255 : 3 + i);
            drive_lit(enc[(i % 2 == 1) ? 7 : 1]);
            tick(6);
        end
        check("sat_final_num", int'(num), 7);
        check("sat_final_valid", int'(valid), 1);
        check("sat_final_errcnt", int'(err_cnt), 255);

        // Loopback count 0..F and wrap to 0
        for (int v = 0; v < 17; v++) begin
            n_chg = 0;
            drive_lit(enc[v % 16]);
            tick(6);
            check($sformatf("loop%0d_num", v), int'(num), v % 16);
            check($sformatf("loop%0d_changes", v), n_chg, 1);
        end

        // Input toggling faster than the stability window never commits
        n_chg = 0;
        for (int i = 0; i < 10; i++) begin
            drive_lit(enc[(i % 2 == 1) ? 2 : 1]);
            tick(2);
        end
        check("unstable_num", int'(num), 0);
        check("unstable_valid", int'(valid), 1);
        check("unstable_changes", n_chg, 0);

        // Reset mid-settle, then recommit five edges after release
        drive_lit(enc[5]);
        tick(4);
        check("mid_settle_num", int'(num), 0);
        check("mid_settle_valid", int'(valid), 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_num", int'(num), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_errcnt", int'(err_cnt), 0);
        check("mid_rst_err", int'(err), 0);
        rst = 1'b0;
        tick(4);
        check("post_rst_not_yet", int'(valid), 0);
        tick(1);
        check("post_rst_valid", int'(valid), 1);
        check("post_rst_num", int'(num), 5);
        check("post_rst_change", int'(chg), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
